// File: rtl/sysx_slave_port_if.sv
// sysX slave-side signal bundle: serial bus pins toward the master plus the
// local register/interrupt pins toward the device logic.
interface sysx_slave_port_if;
  logic        iBusClock;
  logic [1:0]  iBusSelect;
  logic [7:0]  iBusMOSI;
  logic [7:0]  oBusMISO;
  logic        oBusMISOEnable;
  logic        oBusInterrupt;
  logic [3:0]  oRegAddress;
  logic [31:0] oRegWriteData;
  logic        oRegWrite;
  logic        oRegRead;
  logic [31:0] iRegReadData;
  logic        iDeviceInterrupt;
  logic        oBusy;

  modport slave (
    input  iBusClock, iBusSelect, iBusMOSI, iRegReadData, iDeviceInterrupt,
    output oBusMISO, oBusMISOEnable, oBusInterrupt, oRegAddress,
           oRegWriteData, oRegWrite, oRegRead, oBusy
  );

  modport master (
    output iBusClock, iBusSelect, iBusMOSI, iRegReadData, iDeviceInterrupt,
    input  oBusMISO, oBusMISOEnable, oBusInterrupt, oRegAddress,
           oRegWriteData, oRegWrite, oRegRead, oBusy
  );
endinterface

// File: rtl/sysx_slave_port.sv
// sysX bus target endpoint: turns a command byte plus four data bytes into one
// local register read or write, and reports device interrupts to the master.
module sysx_slave_port #(
  parameter logic [1:0] pSelectCode = 2'h1,
  parameter int         pSyncStages = 2
) (
  input logic              iClock,
  input logic              iReset,
  sysx_slave_port_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COMMAND, FETCH, DATA, DONE} state_t;

  localparam int SyncWidth = 12;

  logic [SyncWidth-1:0] syncIn;
  logic [SyncWidth-1:0] syncOut;
  logic [SyncWidth-1:0] sync_q [pSyncStages];

  logic       busClkSync, devIntSync;
  logic [1:0] selSync;
  logic [7:0] mosiSync;
  logic       selected, busRise, devRise;
  logic       busClkPrev_q, devIntPrev_q, selPrev_q, busEdge_q;
  logic [7:0] mosi_q;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic        isWrite_q, isWrite_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  miso_q, miso_d;
  logic        misoEn_q, misoEn_d;
  logic        regWrite_q, regWrite_d;
  logic        regRead_q, regRead_d;
  logic        pending_q, pending_d;
  logic        ack;

  assign syncIn  = {bus.iBusClock, bus.iBusSelect, bus.iBusMOSI, bus.iDeviceInterrupt};
  assign syncOut = sync_q[pSyncStages-1];
  assign {busClkSync, selSync, mosiSync, devIntSync} = syncOut;

  assign selected = (selSync == pSelectCode);
  assign busRise  = busClkSync & ~busClkPrev_q;
  assign devRise  = devIntSync & ~devIntPrev_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < pSyncStages; i++) sync_q[i] <= '0;
      busClkPrev_q <= 1'b0;
      devIntPrev_q <= 1'b0;
      selPrev_q    <= 1'b0;
      busEdge_q    <= 1'b0;
      mosi_q       <= 8'h00;
    end else begin
      sync_q[0] <= syncIn;
      for (int i = 1; i < pSyncStages; i++) sync_q[i] <= sync_q[i-1];
      busClkPrev_q <= busClkSync;
      devIntPrev_q <= devIntSync;
      selPrev_q    <= selected;
      busEdge_q    <= busRise;
      if (busRise) mosi_q <= mosiSync;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 4'h0;
      isWrite_q  <= 1'b0;
      wdata_q    <= 32'h0;
      shift_q    <= 32'h0;
      miso_q     <= 8'h00;
      misoEn_q   <= 1'b0;
      regWrite_q <= 1'b0;
      regRead_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      isWrite_q  <= isWrite_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      miso_q     <= miso_d;
      misoEn_q   <= misoEn_d;
      regWrite_q <= regWrite_d;
      regRead_q  <= regRead_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    isWrite_d  = isWrite_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    miso_d     = miso_q;
    misoEn_d   = misoEn_q;
    regWrite_d = 1'b0;
    regRead_d  = 1'b0;
    ack        = 1'b0;

    if (state_q != IDLE && !selected) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      miso_d   = 8'h00;
      misoEn_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (selected && !selPrev_q) begin
            state_d = COMMAND;
            cnt_d   = 3'd0;
          end
        end
        COMMAND: begin
          // A nonzero count here marks the cycle the read strobe is out, so
          // FETCH lands on the cycle the device returns the word.
          if (cnt_q != 3'd0) begin
            state_d = FETCH;
            cnt_d   = 3'd0;
          end else if (busEdge_q) begin
            addr_d    = mosi_q[3:0];
            isWrite_d = mosi_q[7];
            ack       = mosi_q[6];
            if (mosi_q[7]) begin
              state_d = DATA;
            end else begin
              regRead_d = 1'b1;
              cnt_d     = 3'd1;
            end
          end
        end
        FETCH: begin
          shift_d  = bus.iRegReadData;
          miso_d   = bus.iRegReadData[31:24];
          misoEn_d = 1'b1;
          state_d  = DATA;
          cnt_d    = 3'd0;
        end
        DATA: begin
          if (busEdge_q) begin
            cnt_d = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
            if (isWrite_q) begin
              wdata_d = {wdata_q[23:0], mosi_q};
              if (cnt_q == 3'd3) begin
                regWrite_d = 1'b1;
                state_d    = DONE;
              end
            end else if (cnt_q == 3'd3) begin
              miso_d  = 8'h00;
              state_d = DONE;
            end else begin
              miso_d  = shift_q[23:16];
              shift_d = {shift_q[23:0], 8'h00};
            end
          end
        end
        DONE: begin
          miso_d = 8'h00;
        end
        default: state_d = IDLE;
      endcase
    end

    // A device request arriving with an acknowledge must not be lost.
    pending_d = devRise ? 1'b1 : (ack ? 1'b0 : pending_q);
  end

  assign bus.oBusMISO       = miso_q;
  assign bus.oBusMISOEnable = misoEn_q & selected;
  assign bus.oBusInterrupt  = pending_q;
  assign bus.oRegAddress    = addr_q;
  assign bus.oRegWriteData  = wdata_q;
  assign bus.oRegWrite      = regWrite_q;
  assign bus.oRegRead       = regRead_q;
  assign bus.oBusy          = (state_q != IDLE);

endmodule

// File: doc/sysx_slave_port.md
Name: sysx_slave_port

Overview:
- Target-side endpoint of the sysX serial bus: responds to the sysX master's byte-wide MOSI/MISO, bus clock, 2-bit select and interrupt lines.
- Converts bus transactions into single-word register reads and writes on a local device-side register interface.
- Raises the bus interrupt on behalf of device logic.
- Sits inside each peripheral attached to the sysX bus and runs on the peripheral's own clock.

Parameters:
- pSelectCode, 2'h1, select value addressing this slave; any other value on iBusSelect means deselected.
- pSyncStages, 2, flip-flop depth of the synchronisers on iBusClock, iBusSelect and iBusMOSI (minimum 2).

Ports:
- iClock  in  1  slave clock; must be at least 8x the sysX bus clock frequency.
- iReset  in  1  synchronous, active-high reset.
- iBusClock  in  1  sysX bus clock from master; asynchronous to iClock.
- iBusSelect  in  2  sysX select lines.
- iBusMOSI  in  8  master-to-slave data byte.
- oBusMISO  out  8  slave-to-master data byte.
- oBusMISOEnable  out  1  high when this slave drives MISO; the top-level tri-state uses it.
- oBusInterrupt  out  1  pending-interrupt request to master, level.
- oRegAddress  out  4  local register index.
- oRegWriteData  out  32  local write data.
- oRegWrite  out  1  one-cycle write strobe.
- oRegRead  out  1  one-cycle read strobe.
- iRegReadData  in  32  local read data; valid the cycle after oRegRead.
- iDeviceInterrupt  in  1  device interrupt request; rising edge sets pending.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (iReset high at iClock posedge):
  - State goes to IDLE.
  - All outputs go to 0: oBusMISO=8'h00, oBusMISOEnable=0, oBusInterrupt=0, strobes=0, oRegAddress=0, oRegWriteData=0, oBusy=0.
  - Synchronisers, edge detector, byte counter and pending flag are cleared.
  - Reset mid-transaction aborts it with no strobe.
- Synchronisation and sampling:
  - iBusClock, iBusSelect and iBusMOSI pass through pSyncStages synchronisers.
  - A bus rising edge is detected when the synchronised clock goes 0->1; it is acted on one iClock later.
  - MOSI is sampled from the synchronised copy on the detected edge.
  - The master changes MOSI on the bus falling edge, so the data is stable.
- Selected = synchronised iBusSelect == pSelectCode.
- Command byte format:
  - bit7: 1=write, 0=read.
  - bit6: 1=interrupt acknowledge (clears pending).
  - bits5:4: reserved, ignored.
  - bits3:0: register index.
- States:
  - IDLE: waits for selected. Goes to COMMAND when selected rises; byte counter=0.
  - COMMAND: on the first bus rising edge, latches the command byte into oRegAddress and the direction flag.
    - If bit6 is set, pending is cleared the same cycle.
    - Read: pulses oRegRead the next iClock, then goes to FETCH.
    - Write: goes to DATA.
  - FETCH: one cycle. Latches iRegReadData into the shift register, drives oBusMISO=bits31:24, sets oBusMISOEnable=1, then goes to DATA.
  - DATA: counts bus rising edges 1..4.
    - Write: each edge shifts the MOSI byte into oRegWriteData MSB-first. After edge 4, pulses oRegWrite for exactly one cycle and goes to DONE.
    - Read: after each edge k (k=1..3), the next byte is placed on oBusMISO (bits23:16, 15:8, 7:0), and it must be stable before edge k+1. After edge 4, goes to DONE.
  - DONE: further bus edges are ignored, oBusMISO=8'h00 with enable held while selected. Goes to IDLE when deselected; oBusMISOEnable drops the same cycle.
- Deselect:
  - Deselect in any state other than IDLE returns to IDLE next cycle with oBusMISOEnable=0.
  - A write aborted before edge 4 produces no oRegWrite. An aborted read has already issued its oRegRead; that is acceptable.
- oBusMISOEnable is never high while deselected.
- Interrupt:
  - Pending is set on a synchronised rising edge of iDeviceInterrupt. oBusInterrupt = pending.
  - If a set and an acknowledge land in the same cycle, set wins.
- Width rules: the byte counter is 3-bit and saturates at 4. The data word is exactly 32 bits with no wrap.

Test Plan:
- Write: select=1, bytes 0x83,0xDE,0xAD,0xBE,0xEF -> single oRegWrite pulse with oRegAddress=4'h3 and oRegWriteData=32'hDEADBEEF; MISO enable stays 0 throughout.
- Read: command 0x05 with iRegReadData=32'h12345678 -> one oRegRead pulse with oRegAddress=5; master samples MISO 0x12,0x34,0x56,0x78 at edges 1-4; oBusMISOEnable=0 after deselect.
- Abort: write 0x81,0xAA,0xBB then deselect -> no oRegWrite, state IDLE, oBusy=0; a following full write to reg 1 with 0x00000001 succeeds.
- Wrong select: select=2 with a full write sequence -> no strobes, oBusMISOEnable=0, oBusy=0.
- Interrupt: pulse iDeviceInterrupt -> oBusInterrupt=1 within pSyncStages+2 cycles; command 0x40 plus 4 bytes -> oBusInterrupt=0. Simultaneous set and ack -> oBusInterrupt stays 1.
- Reset mid-read after edge 2 -> all outputs 0 the next cycle; the next transaction reads correctly.
